// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller_pkg
// Brief    : Shared types, constants and helpers for the fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_controller_pkg;

    // Bytes per instruction word; the PC advances by this amount per fetch.
    localparam int WORD_BYTES = 4;

    // Fetch controller operating state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    // One buffered fetch: the address it came from and the fetched word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A PC is fetchable when it is word aligned and inside the memory image.
    function automatic logic pc_is_legal(input logic [31:0] pc, input logic [31:0] limit);
        return (pc[1:0] == 2'b00) && (pc < limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller_if
// Brief    : Valid/ready handoff from the fetch stage to decode.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_controller_if;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    // Fetch side produces {pc, instr}; decode side returns ready.
    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_controller_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller_buffer
// Brief    : Small FIFO of fetch entries with push/pop/flush and head read.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_controller_buffer
    import fetch_controller_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         push_i,
    input  wire fetch_entry_t push_data_i,
    input  wire logic         pop_i,
    input  wire logic         flush_i,
    output logic              full_o,
    output logic              empty_o,
    output fetch_entry_t      head_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_q, wr_d;
    logic [c_PTR_W-1:0] rd_q, rd_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o  = (cnt_q == c_CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    // A pop frees a slot in the same cycle, so push is allowed when full and popping.
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    // Pointer and occupancy update; flush discards everything.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (w_do_push) begin
                wr_d = wr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_d = rd_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Storage and pointer registers; reset clears contents so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (w_do_push && !flush_i) begin
                mem_q[wr_q] <= push_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Brief    : Owns the PC, reads the combinational instruction memory, buffers
//            {pc, instr} pairs for decode and handles redirects and faults.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 128,
    parameter int          BUF_DEPTH  = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         fetch_en_i,
    output logic [31:0]       imem_addr_o,
    input  wire logic [31:0]  imem_rdata_i,
    input  wire logic         redirect_valid_i,
    input  wire logic [31:0]  redirect_pc_i,
    fetch_controller_if.master out_if,
    output logic              fault_o
);

    localparam logic [31:0] c_PC_LIMIT = 32'(IMEM_DEPTH * WORD_BYTES);
    localparam logic [31:0] c_PC_STEP  = 32'(WORD_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    logic         w_push;
    logic         w_pop;
    logic         w_flush;
    logic         w_full;
    logic         w_empty;
    logic         w_pc_legal;
    logic         w_target_legal;
    fetch_entry_t w_push_data;
    fetch_entry_t w_head;

    assign w_pc_legal     = pc_is_legal(pc_q, c_PC_LIMIT);
    assign w_target_legal = pc_is_legal(redirect_pc_i, c_PC_LIMIT);

    assign w_push_data.pc    = pc_q;
    assign w_push_data.instr = imem_rdata_i;

    // Decode consumes the head on a handshake, in any state.
    assign w_pop = out_if.out_valid && out_if.out_ready;

    assign imem_addr_o      = pc_q;
    assign fault_o          = (state_q == FAULT);
    assign out_if.out_valid = !w_empty;
    assign out_if.out_pc    = w_head.pc;
    assign out_if.out_instr = w_head.instr;

    fetch_controller_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .flush_i     (w_flush),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .head_o      (w_head)
    );

    // Next state, next PC and buffer control; a redirect overrides fetching.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        w_push  = 1'b0;
        w_flush = 1'b0;
        if (redirect_valid_i) begin
            w_flush = 1'b1;
            pc_d    = redirect_pc_i;
            if (!w_target_legal) begin
                state_d = FAULT;
            end else if (state_q == FAULT) begin
                state_d = RUN;
            end else if ((state_q == RUN) && !fetch_en_i) begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en_i) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!fetch_en_i) begin
                        state_d = IDLE;
                    end else if (!w_pc_legal) begin
                        // Range check also catches pc+4 running past the top of memory.
                        state_d = FAULT;
                    end else if (!w_full || w_pop) begin
                        w_push = 1'b1;
                        pc_d   = pc_q + c_PC_STEP;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Brief    : Self-checking bench for fetch_controller against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_DEPTH = 128;
    localparam int          BUF_DEPTH  = 2;
    localparam int          M_IDLE     = 0;
    localparam int          M_RUN      = 1;
    localparam int          M_FAULT    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        fault;

    logic [31:0] imem [IMEM_DEPTH];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: mode, PC and an ordered queue of buffered fetches.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] q_pc [$];
    logic [31:0] q_instr [$];

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_PC   (RESET_PC),
        .IMEM_DEPTH (IMEM_DEPTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en_i       (fetch_en),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .out_if           (bus.master),
        .fault_o          (fault)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory.
    always_comb begin
        imem_rdata = 32'hDEAD_BEEF;
        if (imem_addr < 32'(IMEM_DEPTH * 4)) begin
            imem_rdata = imem[int'(imem_addr >> 2)];
        end
    end

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (longint'(a) < longint'(IMEM_DEPTH * 4));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = RESET_PC;
        q_pc.delete();
        q_instr.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit pop;
        bit push;
        pop  = (q_pc.size() != 0) && bus.out_ready;
        push = 1'b0;
        if (redirect_valid) begin
            q_pc.delete();
            q_instr.delete();
            m_pc = redirect_pc;
            if (!legal(redirect_pc))                 m_mode = M_FAULT;
            else if (m_mode == M_FAULT)              m_mode = M_RUN;
            else if (m_mode == M_RUN && !fetch_en)   m_mode = M_IDLE;
        end else begin
            if (m_mode == M_IDLE) begin
                if (fetch_en) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (!fetch_en)                                m_mode = M_IDLE;
                else if (!legal(m_pc))                        m_mode = M_FAULT;
                else if (q_pc.size() < BUF_DEPTH || pop)      push = 1'b1;
            end
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_instr.pop_front());
            end
            if (push) begin
                q_pc.push_back(m_pc);
                q_instr.push_back(imem[int'(m_pc >> 2)]);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(bus.out_valid), 32'(q_pc.size() != 0));
        check("fault", 32'(fault), 32'(m_mode == M_FAULT));
        check("imem_addr", imem_addr, m_pc);
        if (q_pc.size() != 0) begin
            check("out_pc", bus.out_pc, q_pc[0]);
            check("out_instr", bus.out_instr, q_instr[0]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_pc", bus.out_pc, 32'd0);
        check("rst_instr", bus.out_instr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 32'h0000_0013;
        model_reset();
        #2;
        do_reset();

        // Streaming fetch with decode always ready.
        fetch_en = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick(); check("t1_pc0", bus.out_pc, 32'h0);
        tick(); check("t1_pc4", bus.out_pc, 32'h4);
        tick(); check("t1_pc8", bus.out_pc, 32'h8);

        // Backpressure fills the buffer and stalls the PC.
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = $urandom;
        do_reset();
        fetch_en = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t2_hold_pc", bus.out_pc, 32'h0);
        check("t2_stall_addr", imem_addr, 32'h8);
        bus.out_ready = 1'b1;
        tick(); check("t2_pc4", bus.out_pc, 32'h4);
        tick(); check("t2_pc8", bus.out_pc, 32'h8);

        // Redirect while full; no stale entries survive.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick(); check("t3_flush", 32'(bus.out_valid), 32'd0);
        redirect_valid = 1'b0;
        tick(); check("t3_pc40", bus.out_pc, 32'h40);
        tick(); check("t3_pc44", bus.out_pc, 32'h44);

        // Misaligned redirect faults; a legal redirect recovers.
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        tick(); check("t4_fault", 32'(fault), 32'd1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t4_nopush", 32'(bus.out_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        tick(); check("t4_clear", 32'(fault), 32'd0);
        redirect_valid = 1'b0;
        tick(); check("t4_pc10", bus.out_pc, 32'h10);

        // Run off the top of memory.
        redirect_valid = 1'b1;
        redirect_pc = 32'h1F0;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_drained", 32'(bus.out_valid), 32'd0);

        // Reset mid-stream with a full buffer.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        do_reset();
        fetch_en = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick(); check("t6_restart", bus.out_pc, RESET_PC);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            fetch_en = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'($urandom_range(0, IMEM_DEPTH - 1)) << 2;
                1:       redirect_pc = 32'($urandom_range(0, 4 * IMEM_DEPTH - 1));
                2:       redirect_pc = 32'h200 + 32'($urandom_range(0, 4095));
                default: redirect_pc = 32'h1E0 + (32'($urandom_range(0, 7)) << 2);
            endcase
            if ($urandom_range(0, 199) == 0) begin
                redirect_valid = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
